// File: rtl/host_job_sequencer.sv
// Host job sequencer: runs a table of jobs, programming four slave registers per job and polling a status register until it returns zero.
// Optional HOST_SEQ_TIMEOUT_EN: caps status reads per job at TIMEOUT_POLLS and raises a sticky timeout_err.
module host_job_sequencer #(
  parameter int         ADDR_W        = 36,
  parameter int         DATA_W        = 128,
  parameter int         NUM_JOBS      = 4,
  parameter longint     REG_BASE      = 0,
  parameter longint     REG_STRIDE    = 16,
  parameter int         START_DELAY   = 128,
  parameter int         POLL_GAP      = 8,
  parameter logic [3:0] START_MASK    = 4'b1111,
  parameter int         TIMEOUT_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [3:0]        ld_idx,
  input  logic [1:0]        ld_field,
  input  logic [63:0]       ld_data,
  output logic [ADDR_W-1:0] slave_address,
  output logic              slave_wrreq,
  input  logic              slave_wrack,
  output logic [DATA_W-1:0] slave_datain,
  output logic              slave_rdreq,
  input  logic              slave_rdack,
  input  logic [DATA_W-1:0] slave_dataout,
  output logic              busy,
  output logic              done,
  output logic [3:0]        job_idx,
  output logic [4:0]        jobs_ok,
  output logic              timeout_err
);

  localparam int IDX_W = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(REG_BASE);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(REG_STRIDE);

  typedef enum logic [3:0] {
    S_IDLE, S_DELAY, S_WR0, S_WR1, S_WR2, S_WR3, S_RD, S_GAP, S_NEXT, S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] datain_reg, datain_next;
  logic              wrreq_reg, wrreq_next;
  logic              rdreq_reg, rdreq_next;
  logic [3:0]        job_idx_reg, job_idx_next;
  logic [4:0]        jobs_ok_reg, jobs_ok_next;
  logic [7:0]        delay_cnt_reg, delay_cnt_next;
  logic [7:0]        gap_cnt_reg, gap_cnt_next;

`ifdef HOST_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  logic [PW-1:0] poll_cnt_reg, poll_cnt_next;
  logic          timeout_reg, timeout_next;
`endif

  // Register addresses 0..3 are the job fields/start mask, 4 is status; wrap at ADDR_W.
  logic [ADDR_W-1:0] reg_addr [5];
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_addr
      assign reg_addr[gi] = BASE_A + STEP_A * ADDR_W'(gi);
    end
  endgenerate

  // Job table: not reset, loadable only while idle.
  logic [23:0] geom_mem [NUM_JOBS];
  logic [51:0] src_mem  [NUM_JOBS];
  logic [51:0] dst_mem  [NUM_JOBS];

  logic [IDX_W-1:0] ld_sel, cur_sel;
  logic             ld_ok;
  assign ld_sel  = ld_idx[IDX_W-1:0];
  assign cur_sel = job_idx_reg[IDX_W-1:0];
  assign ld_ok   = ld_valid && (state_reg == S_IDLE) && (int'(ld_idx) < NUM_JOBS);

  always_ff @(posedge clk) begin
    if (ld_ok) begin
      case (ld_field)
        2'd0:    geom_mem[ld_sel] <= ld_data[23:0];
        2'd1:    src_mem[ld_sel]  <= ld_data[51:0];
        2'd2:    dst_mem[ld_sel]  <= ld_data[51:0];
        default: ;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ld_data[63:52], slave_dataout[DATA_W-1:4]};

  logic [1:0]        wr_k;
  logic [DATA_W-1:0] wr_field;
  always_comb begin
    wr_k = 2'd0;
    case (state_reg)
      S_WR1:   wr_k = 2'd1;
      S_WR2:   wr_k = 2'd2;
      S_WR3:   wr_k = 2'd3;
      default: wr_k = 2'd0;
    endcase
    wr_field = '0;
    case (wr_k)
      2'd0:    wr_field = DATA_W'(geom_mem[cur_sel]);
      2'd1:    wr_field = DATA_W'(src_mem[cur_sel]);
      2'd2:    wr_field = DATA_W'(dst_mem[cur_sel]);
      default: wr_field = DATA_W'(START_MASK);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    datain_next    = datain_reg;
    wrreq_next     = wrreq_reg;
    rdreq_next     = rdreq_reg;
    job_idx_next   = job_idx_reg;
    jobs_ok_next   = jobs_ok_reg;
    delay_cnt_next = delay_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
`ifdef HOST_SEQ_TIMEOUT_EN
    poll_cnt_next  = poll_cnt_reg;
    timeout_next   = timeout_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_DELAY;
          job_idx_next   = '0;
          jobs_ok_next   = '0;
          delay_cnt_next = '0;
`ifdef HOST_SEQ_TIMEOUT_EN
          poll_cnt_next  = '0;
          timeout_next   = 1'b0;
`endif
        end
      end
      S_DELAY: begin
        if (delay_cnt_reg == 8'(START_DELAY - 1)) begin
          state_next     = S_WR0;
          delay_cnt_next = '0;
        end else begin
          delay_cnt_next = delay_cnt_reg + 8'd1;
        end
      end
      S_WR0, S_WR1, S_WR2, S_WR3: begin
        // Each write spends one cycle with the request low to load address/data.
        if (!wrreq_reg) begin
          addr_next   = reg_addr[{1'b0, wr_k}];
          datain_next = wr_field;
          wrreq_next  = 1'b1;
        end else if (slave_wrack) begin
          wrreq_next = 1'b0;
          case (state_reg)
            S_WR0:   state_next = S_WR1;
            S_WR1:   state_next = S_WR2;
            S_WR2:   state_next = S_WR3;
            default: state_next = S_RD;
          endcase
        end
      end
      S_RD: begin
        if (!rdreq_reg) begin
          addr_next  = reg_addr[3'd4];
          rdreq_next = 1'b1;
        end else if (slave_rdack) begin
          rdreq_next = 1'b0;
`ifdef HOST_SEQ_TIMEOUT_EN
          poll_cnt_next = poll_cnt_reg + 1'b1;
`endif
          if (slave_dataout[3:0] == 4'b0000) begin
            state_next   = S_NEXT;
            jobs_ok_next = jobs_ok_reg + 5'd1;
          end
`ifdef HOST_SEQ_TIMEOUT_EN
          else if (poll_cnt_reg == PW'(TIMEOUT_POLLS - 1)) begin
            timeout_next = 1'b1;
            state_next   = S_NEXT;
          end
`endif
          else if (POLL_GAP == 0) begin
            state_next = S_RD;
          end else begin
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 8'(POLL_GAP - 1)) begin
          state_next   = S_RD;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
      S_NEXT: begin
        if (job_idx_reg == 4'(NUM_JOBS - 1)) begin
          state_next = S_DONE;
        end else begin
          state_next     = S_DELAY;
          job_idx_next   = job_idx_reg + 4'd1;
          delay_cnt_next = '0;
`ifdef HOST_SEQ_TIMEOUT_EN
          poll_cnt_next  = '0;
`endif
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      datain_reg    <= '0;
      wrreq_reg     <= 1'b0;
      rdreq_reg     <= 1'b0;
      job_idx_reg   <= '0;
      jobs_ok_reg   <= '0;
      delay_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
`ifdef HOST_SEQ_TIMEOUT_EN
      poll_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      datain_reg    <= datain_next;
      wrreq_reg     <= wrreq_next;
      rdreq_reg     <= rdreq_next;
      job_idx_reg   <= job_idx_next;
      jobs_ok_reg   <= jobs_ok_next;
      delay_cnt_reg <= delay_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
`ifdef HOST_SEQ_TIMEOUT_EN
      poll_cnt_reg  <= poll_cnt_next;
      timeout_reg   <= timeout_next;
`endif
    end
  end

  assign slave_address = addr_reg;
  assign slave_datain  = datain_reg;
  assign slave_wrreq   = wrreq_reg;
  assign slave_rdreq   = rdreq_reg;
  assign busy          = (state_reg != S_IDLE);
  assign done          = (state_reg == S_DONE);
  assign job_idx       = job_idx_reg;
  assign jobs_ok       = jobs_ok_reg;
`ifdef HOST_SEQ_TIMEOUT_EN
  assign timeout_err   = timeout_reg;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: doc/host_job_sequencer.md
HOST_JOB_SEQUENCER -- requirements
Module: host_job_sequencer

Interface
REQ-001 The block SHALL take the following parameters: ADDR_W, default 36, slave address width; DATA_W, default 128, slave data width (minimum 64); NUM_JOBS, default 4, job table depth (1..16); REG_BASE, default 0, first register address; REG_STRIDE, default 16, address step between registers; START_DELAY, default 128, idle cycles before each job (1..255); POLL_GAP, default 8, idle cycles between status reads (0..255); START_MASK, default 4'b1111, value written to REG3; TIMEOUT_POLLS, default 1024, maximum status reads per job.
REQ-002 The block SHALL have the following ports: clk in 1 rising-edge clock; rst in 1 synchronous active-high reset; start in 1 begin a run of jobs 0..NUM_JOBS-1; ld_valid in 1 job-table write strobe; ld_idx in 4 job index; ld_field in 2 field select; ld_data in 64 field value; slave_address out ADDR_W; slave_wrreq out 1; slave_wrack in 1; slave_datain out DATA_W; slave_rdreq out 1; slave_rdack in 1; slave_dataout in DATA_W; busy out 1 run in progress; done out 1 one-cycle end-of-run pulse; job_idx out 4 current job; jobs_ok out 5 jobs completed normally; timeout_err out 1 sticky timeout flag.

Function
REQ-003 The job table SHALL hold per job: field 0 {height[23:12], width[11:0]}, field 1 {src_dev[51:36], src_addr[35:0]}, field 2 {dst_dev[51:36], dst_addr[35:0]}; ld_field 3 and ld_idx >= NUM_JOBS SHALL be ignored.
REQ-004 A table write SHALL be accepted only when busy=0; ld_valid while busy=1 SHALL be dropped.
REQ-005 States: IDLE, DELAY, WR0, WR1, WR2, WR3, RD, GAP, NEXT, DONE.
REQ-006 IDLE -> DELAY on start=1 with job_idx<=0, jobs_ok<=0, timeout_err<=0; busy=1 in every state except IDLE.
REQ-007 DELAY SHALL count START_DELAY cycles then enter WR0.
REQ-008 WRk (k=0..3) SHALL drive slave_address=REG_BASE+k*REG_STRIDE, slave_wrreq=1, slave_datain = field k zero-extended to DATA_W (k=3: START_MASK zero-extended).
REQ-009 A write SHALL complete on the edge where slave_wrreq=1 and slave_wrack=1: slave_wrreq registers to 0 and the state advances (WR3 -> RD); slave_wrack while slave_wrreq=0 SHALL be ignored.
REQ-010 RD SHALL drive slave_address=REG_BASE+4*REG_STRIDE, slave_rdreq=1; on slave_rdack=1 slave_rdreq registers to 0 and the poll count increments.
REQ-011 On read completion: slave_dataout[3:0]==4'b0000 -> NEXT with jobs_ok+1; otherwise -> GAP (or back to RD directly when POLL_GAP=0).
REQ-012 GAP SHALL hold both requests low for POLL_GAP cycles then re-enter RD.
REQ-013 NEXT: job_idx==NUM_JOBS-1 -> DONE, else job_idx+1 and -> DELAY.
REQ-014 DONE SHALL assert done for exactly one cycle, then -> IDLE; start in any state other than IDLE SHALL be ignored.
REQ-015 slave_wrreq and slave_rdreq SHALL never be high in the same cycle.
REQ-016 Address arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W.

Reset
REQ-017 On rst=1 at a clock edge, regardless of state: state=IDLE, slave_address=0, slave_datain=0, slave_wrreq=0, slave_rdreq=0, busy=0, done=0, job_idx=0, jobs_ok=0, timeout_err=0, all counters=0.
REQ-018 The job table SHALL NOT be cleared by reset; reset mid-transaction SHALL abandon the outstanding request without waiting for its acknowledge.

Configuration
REQ-019 With HOST_SEQ_TIMEOUT_EN defined: when the poll count reaches TIMEOUT_POLLS without a zero status, the block SHALL set timeout_err=1, not increment jobs_ok, and go to NEXT.
REQ-020 Without HOST_SEQ_TIMEOUT_EN: polling SHALL continue indefinitely, timeout_err SHALL be tied to 0, and no poll counter SHALL be instantiated.

Verification
REQ-021 NUM_JOBS=1, job 0 = {0x020,0x040}, {0x1,0x100000}, {0x2,0x200000}; slave acks after 1 cycle, status 0 on first read -> writes at 0x0,0x10,0x20,0x30 with data 0x020040, 0x0001_000100000, 0x0002_000200000, 0xF; one read at 0x40; done pulse; jobs_ok=1.
REQ-022 Status returns 0x3 for 3 reads then 0x0, POLL_GAP=8 -> 4 reads, each read separated by >=8 cycles with both requests low; jobs_ok=1.
REQ-023 NUM_JOBS=2 -> job_idx 0 then 1, START_DELAY idle cycles before each WR0, single done at end, jobs_ok=2.
REQ-024 HOST_SEQ_TIMEOUT_EN, TIMEOUT_POLLS=4, status stuck at 0x1 -> exactly 4 reads, timeout_err=1, next job starts, jobs_ok excludes the timed-out job.
REQ-025 rst asserted while slave_wrreq=1 in WR2 with wrack withheld -> next cycle all outputs at reset values, state IDLE; table retained (rerun with start reproduces REQ-021 data).
REQ-026 ld_valid during busy=1 -> table unchanged, verified by written data on the next run.
